// File: rtl/tile_packet_encoder.sv
// ============================================================================
// tile_packet_encoder : serialises one tile-request packet (ADDR, NLIMBS,
// REAL[], IMAG[], ITER) onto a valid/ready stream of type-tagged 32-bit words.
// Optional build macro TILE_ENC_PKT_COUNT_EN adds the pkt_count output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tile_packet_encoder #(
    parameter int LIMB_INDEX_BITS = 6,
    parameter int LIMB_SIZE_BITS  = 27
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_real_en,
    input  logic                       wr_imag_en,
    input  logic [LIMB_INDEX_BITS-1:0] wr_index,
    input  logic [LIMB_SIZE_BITS-1:0]  wr_data,
    input  logic                       start,
    input  logic [28:0]                tile_addr,
    input  logic [LIMB_INDEX_BITS-1:0] num_limbs,
    input  logic [15:0]                iter_lim,
    output logic                       busy,
    output logic                       done,
    output logic [31:0]                out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_end_of_stream
`ifdef TILE_ENC_PKT_COUNT_EN
    ,
    output logic [15:0]                pkt_count
`endif
);

    localparam int DEPTH = 1 << LIMB_INDEX_BITS;

    localparam logic [2:0] TYPE_ADDR   = 3'd0;
    localparam logic [2:0] TYPE_NLIMBS = 3'd1;
    localparam logic [2:0] TYPE_REAL   = 3'd2;
    localparam logic [2:0] TYPE_IMAG   = 3'd3;
    localparam logic [2:0] TYPE_ITER   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_NLIMBS = 3'd2,
        S_REAL   = 3'd3,
        S_IMAG   = 3'd4,
        S_ITER   = 3'd5,
        S_GAP    = 3'd6
    } state_t;

    state_t                     state;
    logic [LIMB_INDEX_BITS-1:0] limb_cnt;
    logic [LIMB_INDEX_BITS-1:0] nl_reg;
    logic [15:0]                iter_reg;

    logic [LIMB_SIZE_BITS-1:0]  real_mem [DEPTH];
    logic [LIMB_SIZE_BITS-1:0]  imag_mem [DEPTH];

    logic                       fire;
    logic                       last_limb;
    logic [LIMB_INDEX_BITS-1:0] cnt_next;

    assign fire      = out_valid && out_ready;
    assign last_limb = (limb_cnt == (nl_reg - LIMB_INDEX_BITS'(1)));
    assign cnt_next  = limb_cnt + LIMB_INDEX_BITS'(1);

    // Storage is frozen outside IDLE so the packet in flight cannot change.
    always_ff @(posedge clock) begin
        if (state == S_IDLE) begin
            if (wr_real_en) real_mem[wr_index] <= wr_data;
            if (wr_imag_en) imag_mem[wr_index] <= wr_data;
        end
    end

    // Each handshake loads the following word, so consecutive limbs need no bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= S_IDLE;
            limb_cnt          <= '0;
            nl_reg            <= '0;
            iter_reg          <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_end_of_stream <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_ADDR;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_data  <= {TYPE_ADDR, tile_addr};
                        nl_reg    <= num_limbs;
                        iter_reg  <= iter_lim;
                    end
                end
                S_ADDR: begin
                    if (fire) begin
                        state    <= S_NLIMBS;
                        out_data <= {TYPE_NLIMBS, 29'(nl_reg)};
                    end
                end
                S_NLIMBS: begin
                    if (fire) begin
                        limb_cnt <= '0;
                        if (nl_reg == '0) begin
                            state             <= S_ITER;
                            out_data          <= {TYPE_ITER, 29'(iter_reg)};
                            out_end_of_stream <= 1'b1;
                        end else begin
                            state    <= S_REAL;
                            out_data <= {TYPE_REAL, 29'(real_mem['0])};
                        end
                    end
                end
                S_REAL: begin
                    if (fire) begin
                        if (last_limb) begin
                            state    <= S_IMAG;
                            limb_cnt <= '0;
                            out_data <= {TYPE_IMAG, 29'(imag_mem['0])};
                        end else begin
                            limb_cnt <= cnt_next;
                            out_data <= {TYPE_REAL, 29'(real_mem[cnt_next])};
                        end
                    end
                end
                S_IMAG: begin
                    if (fire) begin
                        if (last_limb) begin
                            state             <= S_ITER;
                            limb_cnt          <= '0;
                            out_data          <= {TYPE_ITER, 29'(iter_reg)};
                            out_end_of_stream <= 1'b1;
                        end else begin
                            limb_cnt <= cnt_next;
                            out_data <= {TYPE_IMAG, 29'(imag_mem[cnt_next])};
                        end
                    end
                end
                S_ITER: begin
                    if (fire) begin
                        state             <= S_GAP;
                        out_valid         <= 1'b0;
                        out_data          <= '0;
                        out_end_of_stream <= 1'b0;
                        done              <= 1'b1;
                    end
                end
                S_GAP: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state             <= S_IDLE;
                    busy              <= 1'b0;
                    out_valid         <= 1'b0;
                    out_end_of_stream <= 1'b0;
                end
            endcase
        end
    end

`ifdef TILE_ENC_PKT_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_count <= '0;
        end else if (done) begin
            pkt_count <= pkt_count + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_tile_packet_encoder.sv
// ============================================================================
// tb_tile_packet_encoder : directed self-checking bench for tile_packet_encoder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tile_packet_encoder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wr_real_en = 1'b0;
    logic        wr_imag_en = 1'b0;
    logic [5:0]  wr_index = '0;
    logic [26:0] wr_data = '0;
    logic        start = 1'b0;
    logic [28:0] tile_addr = '0;
    logic [5:0]  num_limbs = '0;
    logic [15:0] iter_lim = '0;
    logic        busy;
    logic        done;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_end_of_stream;
`ifdef TILE_ENC_PKT_COUNT_EN
    logic [15:0] pkt_count;
`endif

    int tests = 0;
    int fails = 0;

    logic [31:0] rx_words[$];
    bit          rx_eos[$];
    int          rx_bubbles;
    bit          rx_timeout;
    logic        rx_gap_valid;
    logic        rx_gap_done;
    logic        rx_after_done;
    logic        rx_after_busy;
    logic        rx_after_valid;

    tile_packet_encoder #(
        .LIMB_INDEX_BITS(6),
        .LIMB_SIZE_BITS (27)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .wr_real_en       (wr_real_en),
        .wr_imag_en       (wr_imag_en),
        .wr_index         (wr_index),
        .wr_data          (wr_data),
        .start            (start),
        .tile_addr        (tile_addr),
        .num_limbs        (num_limbs),
        .iter_lim         (iter_lim),
        .busy             (busy),
        .done             (done),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_end_of_stream(out_end_of_stream)
`ifdef TILE_ENC_PKT_COUNT_EN
        ,
        .pkt_count        (pkt_count)
`endif
    );

    always #5 clock = ~clock;

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_limb(input bit re, input bit im, input logic [5:0] idx, input logic [26:0] val);
        wr_real_en = re;
        wr_imag_en = im;
        wr_index   = idx;
        wr_data    = val;
        tick();
        wr_real_en = 1'b0;
        wr_imag_en = 1'b0;
    endtask

    task automatic do_start(input logic [28:0] a, input logic [5:0] n, input logic [15:0] it);
        tile_addr = a;
        num_limbs = n;
        iter_lim  = it;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Capture a packet with out_ready held high; ends at the first IDLE cycle after GAP.
    task automatic receive(input int max_cycles);
        rx_words.delete();
        rx_eos.delete();
        rx_bubbles = 0;
        rx_timeout = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            if (out_valid) begin
                rx_words.push_back(out_data);
                rx_eos.push_back(out_end_of_stream);
                if (out_end_of_stream) begin
                    tick();
                    rx_gap_valid = out_valid;
                    rx_gap_done  = done;
                    tick();
                    rx_after_done  = done;
                    rx_after_busy  = busy;
                    rx_after_valid = out_valid;
                    rx_timeout     = 1'b0;
                    return;
                end
            end else if (rx_words.size() > 0) begin
                rx_bubbles++;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_data: got %h expected 00000000", out_data); end
        tests++; if (out_end_of_stream !== 1'b0) begin fails++; $display("FAIL reset_eos: got %b expected 0", out_end_of_stream); end
        reset = 1'b0;
        tick();
        tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL idle_after_reset: valid %b busy %b expected 0 0", out_valid, busy); end
    endtask

    task automatic test_basic();
        logic [31:0] exp_w [7] = '{32'h00000055, 32'h20000002, 32'h40000001, 32'h40000002,
                                   32'h60000003, 32'h60000004, 32'h800003E8};
        write_limb(1'b1, 1'b0, 6'd0, 27'h1);
        write_limb(1'b1, 1'b0, 6'd1, 27'h2);
        write_limb(1'b0, 1'b1, 6'd0, 27'h3);
        // Last limb written in the very cycle the start is accepted.
        wr_imag_en = 1'b1; wr_index = 6'd1; wr_data = 27'h4;
        do_start(29'h55, 6'd2, 16'd1000);
        wr_imag_en = 1'b0;
        tests++; if (out_valid !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL basic_latency: valid %b busy %b expected 1 1", out_valid, busy); end
        receive(50);
        tests++; if (rx_timeout) begin fails++; $display("FAIL basic_timeout: got no end_of_stream expected one"); end
        tests++; if (rx_words.size() != 7) begin fails++; $display("FAIL basic_count: got %0d expected 7", rx_words.size()); end
        for (int i = 0; i < 7 && i < rx_words.size(); i++) begin
            tests++; if (rx_words[i] !== exp_w[i]) begin fails++; $display("FAIL basic_word%0d: got %h expected %h", i, rx_words[i], exp_w[i]); end
            tests++; if (rx_eos[i] !== (i == 6)) begin fails++; $display("FAIL basic_eos%0d: got %b expected %b", i, rx_eos[i], (i == 6)); end
        end
        tests++; if (rx_bubbles != 0) begin fails++; $display("FAIL basic_bubbles: got %0d expected 0", rx_bubbles); end
        tests++; if (rx_gap_valid !== 1'b0 || rx_gap_done !== 1'b1) begin fails++; $display("FAIL basic_gap: valid %b done %b expected 0 1", rx_gap_valid, rx_gap_done); end
        tests++; if (rx_after_done !== 1'b0 || rx_after_busy !== 1'b0) begin fails++; $display("FAIL basic_after: done %b busy %b expected 0 0", rx_after_done, rx_after_busy); end
    endtask

    task automatic test_zero_limbs();
        logic [31:0] exp_w [3] = '{32'h00000007, 32'h20000000, 32'h80000005};
        do_start(29'h7, 6'd0, 16'd5);
        receive(30);
        tests++; if (rx_timeout || rx_words.size() != 3) begin fails++; $display("FAIL zero_count: got %0d timeout %b expected 3 0", rx_words.size(), rx_timeout); end
        for (int i = 0; i < 3 && i < rx_words.size(); i++) begin
            tests++; if (rx_words[i] !== exp_w[i]) begin fails++; $display("FAIL zero_word%0d: got %h expected %h", i, rx_words[i], exp_w[i]); end
            tests++; if (rx_eos[i] !== (i == 2)) begin fails++; $display("FAIL zero_eos%0d: got %b expected %b", i, rx_eos[i], (i == 2)); end
        end
        tests++; if (rx_gap_done !== 1'b1) begin fails++; $display("FAIL zero_done: got %b expected 1", rx_gap_done); end
    endtask

    task automatic test_stall();
        logic [63:0] pat = 64'hB53C96E14DA728F3;
        logic [31:0] exp_w [7] = '{32'h00000055, 32'h20000002, 32'h40000001, 32'h40000002,
                                   32'h60000003, 32'h60000004, 32'h800003E8};
        logic [31:0] got[$];
        logic [31:0] held = '0;
        logic        held_eos = 1'b0;
        bit          stalled = 1'b0;
        bit          fin = 1'b0;
        do_start(29'h55, 6'd2, 16'd1000);
        for (int c = 0; c < 300 && !fin; c++) begin
            out_ready = pat[c % 64];
            if (stalled) begin
                tests++;
                if (out_valid !== 1'b1 || out_data !== held || out_end_of_stream !== held_eos) begin
                    fails++; $display("FAIL stall_hold: got %b/%h expected 1/%h", out_valid, out_data, held);
                end
            end
            stalled = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    got.push_back(out_data);
                    if (out_end_of_stream) fin = 1'b1;
                end else begin
                    stalled  = 1'b1;
                    held     = out_data;
                    held_eos = out_end_of_stream;
                end
            end
            tick();
        end
        out_ready = 1'b1;
        tests++; if (!fin) begin fails++; $display("FAIL stall_timeout: got no end_of_stream expected one"); end
        tests++; if (got.size() != 7) begin fails++; $display("FAIL stall_count: got %0d expected 7", got.size()); end
        for (int i = 0; i < 7 && i < got.size(); i++) begin
            tests++; if (got[i] !== exp_w[i]) begin fails++; $display("FAIL stall_word%0d: got %h expected %h", i, got[i], exp_w[i]); end
        end
        tick();
        tick();
    endtask

    task automatic test_busy_ignore();
        logic [31:0] exp_a [6] = '{32'h20000002, 32'h40000001, 32'h40000002, 32'h60000003,
                                   32'h60000004, 32'h80000009};
        logic [31:0] exp_b [5] = '{32'h00000002, 32'h20000001, 32'h40000123, 32'h60000003, 32'h80000000};
        do_start(29'h100, 6'd2, 16'd9);
        tests++; if (out_data !== 32'h00000100) begin fails++; $display("FAIL ignore_addr: got %h expected 00000100", out_data); end
        // Second start and a limb write while the first packet is in flight.
        start = 1'b1; tile_addr = 29'h1ABC; num_limbs = 6'd5;
        wr_real_en = 1'b1; wr_index = 6'd0; wr_data = 27'h123;
        tick();
        start = 1'b0; wr_real_en = 1'b0;
        receive(40);
        tests++; if (rx_timeout || rx_words.size() != 6) begin fails++; $display("FAIL ignore_count: got %0d timeout %b expected 6 0", rx_words.size(), rx_timeout); end
        for (int i = 0; i < 6 && i < rx_words.size(); i++) begin
            tests++; if (rx_words[i] !== exp_a[i]) begin fails++; $display("FAIL ignore_word%0d: got %h expected %h", i, rx_words[i], exp_a[i]); end
        end
        tests++; if (rx_after_valid !== 1'b0 || rx_after_busy !== 1'b0) begin fails++; $display("FAIL ignore_queued: valid %b busy %b expected 0 0", rx_after_valid, rx_after_busy); end
        write_limb(1'b1, 1'b0, 6'd0, 27'h123);
        do_start(29'h2, 6'd1, 16'd0);
        receive(40);
        tests++; if (rx_timeout || rx_words.size() != 5) begin fails++; $display("FAIL newval_count: got %0d timeout %b expected 5 0", rx_words.size(), rx_timeout); end
        for (int i = 0; i < 5 && i < rx_words.size(); i++) begin
            tests++; if (rx_words[i] !== exp_b[i]) begin fails++; $display("FAIL newval_word%0d: got %h expected %h", i, rx_words[i], exp_b[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_w [7] = '{32'h00000010, 32'h20000002, 32'h40000123, 32'h40000002,
                                   32'h60000003, 32'h60000004, 32'h80000003};
        do_start(29'h10, 6'd2, 16'd3);
        tick();
        tick();
        tests++; if (out_data !== 32'h40000123) begin fails++; $display("FAIL mid_real0: got %h expected 40000123", out_data); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_end_of_stream !== 1'b0) begin
            fails++; $display("FAIL mid_reset: valid %b busy %b eos %b expected 0 0 0", out_valid, busy, out_end_of_stream);
        end
        tick();
        do_start(29'h10, 6'd2, 16'd3);
        receive(40);
        tests++; if (rx_timeout || rx_words.size() != 7) begin fails++; $display("FAIL mid_count: got %0d timeout %b expected 7 0", rx_words.size(), rx_timeout); end
        for (int i = 0; i < 7 && i < rx_words.size(); i++) begin
            tests++; if (rx_words[i] !== exp_w[i]) begin fails++; $display("FAIL mid_word%0d: got %h expected %h", i, rx_words[i], exp_w[i]); end
        end
    endtask

    task automatic test_max();
        logic [26:0] re [63];
        logic [26:0] im [63];
        logic [31:0] exp_w[$];
        for (int i = 0; i < 63; i++) begin
            re[i] = (i == 0 || i == 62) ? 27'h7FFFFFF : 27'(i * 32'h10101);
            im[i] = 27'h7FFFFFF ^ 27'(i);
        end
        re[5] = 27'h5A5A5A5;
        im[5] = 27'h5A5A5A5;
        for (int i = 0; i < 63; i++) begin
            if (i == 5) begin
                write_limb(1'b1, 1'b1, 6'(i), re[i]);
            end else begin
                write_limb(1'b1, 1'b0, 6'(i), re[i]);
                write_limb(1'b0, 1'b1, 6'(i), im[i]);
            end
        end
        exp_w.push_back(32'h1FFFFFFF);
        exp_w.push_back(32'h2000003F);
        for (int i = 0; i < 63; i++) exp_w.push_back({3'd2, 2'b00, re[i]});
        for (int i = 0; i < 63; i++) exp_w.push_back({3'd3, 2'b00, im[i]});
        exp_w.push_back(32'h8000FFFF);
        do_start(29'h1FFFFFFF, 6'd63, 16'hFFFF);
        receive(400);
        tests++; if (rx_timeout || rx_words.size() != 129) begin fails++; $display("FAIL max_count: got %0d timeout %b expected 129 0", rx_words.size(), rx_timeout); end
        for (int i = 0; i < 129 && i < rx_words.size(); i++) begin
            tests++; if (rx_words[i] !== exp_w[i]) begin fails++; $display("FAIL max_word%0d: got %h expected %h", i, rx_words[i], exp_w[i]); end
        end
        tests++; if (rx_words.size() > 2 && rx_words[2] !== 32'h47FFFFFF) begin fails++; $display("FAIL max_limb_payload: got %h expected 47FFFFFF", rx_words[2]); end
        tests++; if (rx_bubbles != 0) begin fails++; $display("FAIL max_bubbles: got %0d expected 0", rx_bubbles); end
        tests++; if (rx_eos.size() != 129 || rx_eos[127] !== 1'b0 || rx_eos[128] !== 1'b1) begin fails++; $display("FAIL max_eos: got size %0d expected 129 with eos on last only", rx_eos.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_limbs();
        test_stall();
        test_busy_ignore();
        test_reset_mid();
        test_max();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tile_packet_encoder.md
Name: tile_packet_encoder

Overview:
- Transmit side of the tile-request word stream: host loads c_real/c_imag limbs into local storage, then issues start with tile address, limb count and iteration limit.
- Block serialises one packet of type-tagged 32-bit words with valid/ready handshake and end-of-stream marking.
- Sits between the host/tile scheduler and a tile solver's input port.

Parameters:
LIMB_INDEX_BITS, 6, width of limb index and limb count; storage depth 2**LIMB_INDEX_BITS per component
LIMB_SIZE_BITS, 27, width of one limb (must be <= 29)

Ports:
clock  input  1  clock
reset  input  1  reset, synchronous, active-high
wr_real_en  input  1  write wr_data into real limb store at wr_index
wr_imag_en  input  1  write wr_data into imag limb store at wr_index
wr_index  input  LIMB_INDEX_BITS  limb store write index
wr_data  input  LIMB_SIZE_BITS  limb value
start  input  1  begin packet (accepted only when busy=0)
tile_addr  input  29  tile output address, latched on accepted start
num_limbs  input  LIMB_INDEX_BITS  limbs per component, latched on accepted start
iter_lim  input  16  iteration limit, latched on accepted start
busy  output  1  packet in progress (start not accepted)
done  output  1  one-cycle pulse after packet fully sent
out_data  output  32  stream word {type[2:0], payload[28:0]}
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts word
out_end_of_stream  output  1  high with the last word of packet

Behaviour:
- Reset values: busy=0, done=0, out_valid=0, out_data=0, out_end_of_stream=0, state IDLE, limb counter 0. Limb storage not cleared.
- Word encoding (payload zero-extended to 29 bits): type 0 = tile_addr; 1 = num_limbs; 2 = real limb; 3 = imag limb; 4 = iter_lim.
- Packet order: ADDR, NLIMBS, REAL[0..n-1], IMAG[0..n-1], ITER; total 3+2n words. n=0 skips REAL and IMAG entirely.
- States: IDLE -> ADDR -> NLIMBS -> REAL -> IMAG -> ITER -> GAP -> IDLE. Each word state advances only on out_valid && out_ready. REAL/IMAG advance to next state when the counter equals n-1 on handshake; counter resets to 0 on leaving each.
- Outputs registered: start accepted in cycle T -> out_valid=1 with ADDR word in T+1. busy=1 from T+1 until return to IDLE.
- Handshake: while out_valid=1 and out_ready=0, out_data/out_end_of_stream held stable. Back-to-back handshakes sustain one word per cycle.
- out_end_of_stream=1 only while ITER word is presented.
- GAP: one cycle with out_valid=0 after the ITER handshake. This is the mandatory idle cycle after end-of-stream. done=1 in GAP cycle only.
- start in GAP or any busy state: ignored (no queuing).
- start and limb write in same IDLE cycle: write completes; packet reads updated value.
- Limb writes while busy=1: ignored, so storage is stable during transmission.
- Write with wr_real_en and wr_imag_en both high: both stores written.
- Reset mid-packet: next cycle out_valid=0, busy=0, IDLE; partial packet abandoned (no end_of_stream issued).
- Limb store: synchronous-write, read addressed by internal counter; read path arranged so the limb word is valid in the same cycle the state presents it (no bubble between limbs).

Optional Feature:
- Macro TILE_ENC_PKT_COUNT_EN.
- Defined: adds output pkt_count [15:0]. Reset 0, increments by 1 in each done cycle, wraps 0xFFFF -> 0.
- Undefined: port absent, no counter logic.

Test Plan:
- Load real={0x1,0x2}, imag={0x3,0x4}; start with addr=0x55, n=2, iter=1000; out_ready=1 -> words 0x00000055, 0x20000002, 0x40000001, 0x40000002, 0x60000003, 0x60000004, 0x800003E8 on consecutive cycles; eos only on last; done 1 cycle later with out_valid=0.
- n=0, addr=7, iter=5 -> exactly 3 words 0x00000007, 0x20000000, 0x80000005; eos on third.
- out_ready toggled pseudo-randomly -> same word sequence, data stable while stalled, no drops or duplicates.
- start pulsed while busy and limb write to index 0 mid-packet -> second start ignored; transmitted limb unchanged; next packet uses new limb value.
- Reset asserted during REAL words -> out_valid=0 next cycle, busy=0; fresh start yields full correct packet.
- Limb value 0x7FFFFFF (27-bit max) at n=63 -> payload 0x07FFFFFF with correct type bits; 129 words total. With TILE_ENC_PKT_COUNT_EN, pkt_count increments per packet.
